gray_monitor: RTL
=================

# gray_monitor

Downstream checker for the 3-bit Gray-code step counter. Samples the counter's Gray output and sticky overflow flag every cycle, converts Gray to binary, verifies that every change is exactly one legal forward step, and counts completed laps of the 000→…→100→000 sequence. Illegal transitions and overflow-flag inconsistencies latch a sticky error and a saturating fault count for the test harness and status logic.

## Interface
- LAP_W, 8, width of lap counter
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high; priority over all other inputs
- Gray  in  3  Gray-code value from upstream counter
- Ovf_in  in  1  upstream sticky overflow flag
- Clr  in  1  synchronous clear of Laps/Err/ErrCnt, forces SYNC
- Bin  out  3  registered binary equivalent of Gray
- Step  out  1  one-cycle pulse per legal forward step
- Laps  out  LAP_W  completed laps, saturating at 2^LAP_W-1
- Err  out  1  sticky fault flag
- ErrCnt  out  4  fault count, saturating at 15
- State  out  2  00 SYNC, 01 TRACK, 10 FAULT

## Operation
- Sequence (Gray): 000,001,011,010,110,111,101,100, then 000. succ(g) = bin2gray((gray2bin(g)+1) mod 8); gray2bin: b2=g2, b1=g2^g1, b0=b1^g0.
- Internal regs: prev_g (3b), prev_ovf (1b); both updated with Gray/Ovf_in every non-reset cycle.
- Bin <= gray2bin(Gray) every cycle, all states.
- SYNC: Step=0, no checking. When Gray==000, go TRACK. Otherwise stay.
- TRACK, per sampled cycle, first matching rule wins:
  - Ovf_in 1→0 (prev_ovf=1, Ovf_in=0): if Gray==000, treat as upstream reset, stay TRACK, no step, no error; else fault.
  - Gray==prev_g: hold; Ovf_in 0→1 on a hold cycle is a fault.
  - Gray==succ(prev_g): legal step; Step pulses. If prev_g==100 and Gray==000 (wrap): requires Ovf_in==1, else fault; on success Laps+1 (saturate).
  - Ovf_in 0→1 on a non-wrap legal step: fault.
  - Any other Gray value: fault.
- Fault: Step=0, Err<=1, ErrCnt+1 (saturate 15), State→FAULT, Laps unchanged.
- FAULT: lasts exactly one cycle, then SYNC (relock at next 000). Err remains set.
- Clr (Reset=0): Laps<=0, Err<=0, ErrCnt<=0, Step<=0, State<=SYNC; any step/fault sampled that cycle is discarded. Bin, prev_g, prev_ovf still update.
- Reset: all outputs and internal regs to reset values; overrides Clr.

## Timing
- Reset values: Bin=000, Step=0, Laps=0, Err=0, ErrCnt=0, State=00; prev_g=000, prev_ovf=0.
- All outputs registered; latency 1 cycle from sampled input to Bin/Step/Laps/Err/ErrCnt/State.
- Step is high for exactly one cycle per legal step; back-to-back steps give back-to-back Step pulses.
- Wrap: Laps increments on the same edge Step asserts.
- SYNC→TRACK on the edge after Gray==000 is sampled; the 000 itself is not a step. First checked transition is the next change after lock.
- Upstream Overflow is set on the same edge its output goes 100→000, so Ovf_in and Gray=000 are sampled together; no skew tolerance.
- Fault edge: Err=1, ErrCnt updated, State=10; next edge State=00.
- Reset mid-operation: outputs take reset values on the next edge regardless of state.

## Test plan
- Reset, then Gray held 000 for 2 cycles, then 001,011,010,110,111,101,100 one per cycle -> State=01 after first 000; 7 Step pulses; Bin follows 1..7 one cycle late; Err=0, Laps=0.
- Continue 100→000 with Ovf_in=1 same cycle, then 3 more full laps -> Laps=4, Err=0, Step high on every advance including wraps.
- In TRACK at 011, drive Gray=110 -> next edge Err=1, ErrCnt=1, State=10, Step=0; following edge State=00; stays SYNC until Gray=000, then State=01.
- Wrap 100→000 with Ovf_in=0 -> fault, Laps unchanged, ErrCnt+1; separately Ovf_in 0→1 while Gray holds 010 -> fault.
- Ovf_in 1→0 with Gray=000 (upstream reset) -> no error, State stays 01; then 17 injected faults -> ErrCnt saturates at 15, Err=1.
- Clr asserted same cycle as legal step 001→011 -> Step=0, Laps=0, Err=0, ErrCnt=0, State=00; Reset and Clr together -> reset values.

Source files
------------

// File: rtl/gray_monitor_if.sv
// gray_monitor_if: bundles the sampled upstream counter signals and the
// monitor's status outputs into one port.
//   master : drives Gray/Ovf_in/Clr, observes the status outputs (harness side)
//   slave  : the monitor itself
//   Gray   [2:0]       Gray-code value from the upstream step counter
//   Ovf_in             upstream sticky overflow flag
//   Clr                synchronous clear of Laps/Err/ErrCnt, forces relock
//   Bin    [2:0]       registered binary equivalent of Gray
//   Step               one-cycle pulse per legal forward step
//   Laps   [LAP_W-1:0] completed laps, saturating
//   Err                sticky fault flag
//   ErrCnt [3:0]       saturating fault count
//   State  [1:0]       00 SYNC, 01 TRACK, 10 FAULT
interface gray_monitor_if #(
  parameter int unsigned LAP_W = 8
);
  logic [2:0]       Gray;
  logic             Ovf_in;
  logic             Clr;
  logic [2:0]       Bin;
  logic             Step;
  logic [LAP_W-1:0] Laps;
  logic             Err;
  logic [3:0]       ErrCnt;
  logic [1:0]       State;

  modport master (
    output Gray, Ovf_in, Clr,
    input  Bin, Step, Laps, Err, ErrCnt, State
  );

  modport slave (
    input  Gray, Ovf_in, Clr,
    output Bin, Step, Laps, Err, ErrCnt, State
  );
endinterface

// File: rtl/gray_monitor.sv
// gray_monitor: downstream checker for a 3-bit Gray-code step counter.
// Samples Gray and the upstream sticky overflow flag every cycle, converts
// Gray to binary, checks that every change is one legal forward step, counts
// completed laps and latches a sticky error plus a saturating fault count.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-high; overrides everything including Clr
//   bus   : gray_monitor_if.slave (inputs Gray/Ovf_in/Clr, registered outputs)
module gray_monitor #(
  parameter int unsigned LAP_W = 8
) (
  input logic           Clk,
  input logic           Reset,
  gray_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    StSync  = 2'b00,
    StTrack = 2'b01,
    StFault = 2'b10
  } state_e;

  state_e           state_q;
  logic [2:0]       bin_q;
  logic             step_q;
  logic [LAP_W-1:0] laps_q;
  logic             err_q;
  logic [3:0]       err_cnt_q;
  logic [2:0]       prev_g_q;
  logic             prev_ovf_q;

  logic [2:0] cur_b;
  logic [2:0] prev_b;
  logic       ovf_fall;
  logic       ovf_rise;
  logic       is_succ;
  logic       is_wrap;
  logic       legal_step;
  logic       fault;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // Classification of the current sample against the previous one; only
  // acted on while tracking. Rule order matters: first match wins.
  always_comb begin
    cur_b      = gray2bin(bus.Gray);
    prev_b     = gray2bin(prev_g_q);
    ovf_fall   = prev_ovf_q & ~bus.Ovf_in;
    ovf_rise   = ~prev_ovf_q & bus.Ovf_in;
    is_succ    = (cur_b == 3'(prev_b + 3'd1));
    is_wrap    = is_succ && (prev_g_q == 3'b100);
    legal_step = 1'b0;
    fault      = 1'b0;
    if (ovf_fall) begin
      // Overflow dropping together with 000 means the upstream counter was reset.
      fault = (bus.Gray != 3'b000);
    end else if (bus.Gray == prev_g_q) begin
      fault = ovf_rise;
    end else if (is_wrap) begin
      // Upstream sets its overflow on the very edge it wraps: no skew allowed.
      if (bus.Ovf_in) legal_step = 1'b1;
      else            fault      = 1'b1;
    end else if (is_succ) begin
      if (ovf_rise) fault      = 1'b1;
      else          legal_step = 1'b1;
    end else begin
      fault = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StSync;
      bin_q      <= 3'b000;
      step_q     <= 1'b0;
      laps_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= 4'd0;
      prev_g_q   <= 3'b000;
      prev_ovf_q <= 1'b0;
    end else begin
      bin_q      <= cur_b;
      prev_g_q   <= bus.Gray;
      prev_ovf_q <= bus.Ovf_in;
      step_q     <= 1'b0;
      if (bus.Clr) begin
        // Whatever was sampled this cycle is discarded.
        state_q   <= StSync;
        laps_q    <= '0;
        err_q     <= 1'b0;
        err_cnt_q <= 4'd0;
      end else begin
        case (state_q)
          StSync: begin
            if (bus.Gray == 3'b000) state_q <= StTrack;
          end
          StTrack: begin
            if (fault) begin
              state_q <= StFault;
              err_q   <= 1'b1;
              if (err_cnt_q != 4'hf) err_cnt_q <= err_cnt_q + 4'd1;
            end else if (legal_step) begin
              step_q <= 1'b1;
              if (is_wrap && (laps_q != '1)) laps_q <= laps_q + LAP_W'(1);
            end
          end
          StFault: state_q <= StSync;
          default: state_q <= StSync;
        endcase
      end
    end
  end

  assign bus.Bin    = bin_q;
  assign bus.Step   = step_q;
  assign bus.Laps   = laps_q;
  assign bus.Err    = err_q;
  assign bus.ErrCnt = err_cnt_q;
  assign bus.State  = state_q;

endmodule
